// File: rtl/lzw_dict_port.sv
// Request/response front end for the single-port LZW dictionary RAM.
// Serialises read/write/insert requests onto the RAM and owns next-free-code allocation.
module lzw_dict_port #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4096,
   parameter int FIRST_CODE = 256,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_op,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [ADDR_WIDTH-1:0] rsp_code,
   output logic                  rsp_err,
   input  logic                  clear,
   output logic [ADDR_WIDTH-1:0] next_code,
   output logic                  dict_full,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   output logic                  ram_cs,
   output logic                  ram_we,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   input  logic                  ram_valid
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [1:0] OP_READ   = 2'b00;
   localparam logic [1:0] OP_INSERT = 2'b10;
   localparam logic [1:0] OP_RSVD   = 2'b11;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]      WAIT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [ADDR_WIDTH-1:0] FIRST_C   = ADDR_WIDTH'(FIRST_CODE);
   localparam logic [ADDR_WIDTH-1:0] LAST_C    = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

   state_t                state;
   logic [1:0]            op_q;
   logic [CNT_W-1:0]      wait_cnt;
   logic                  accept;
   logic                  addr_bad;
   logic                  accept_err;
   logic [ADDR_WIDTH-1:0] target_addr;

   assign req_ready   = (state == IDLE) & ~clear;
   assign accept      = req_valid & req_ready;
   // Extra MSB keeps the range check meaningful when DEPTH == 2**ADDR_WIDTH.
   assign addr_bad    = ({1'b0, req_addr} >= DEPTH_EXT);
   assign accept_err  = (req_op == OP_RSVD)
                      | ((req_op != OP_INSERT) & addr_bad)
                      | ((req_op == OP_INSERT) & dict_full);
   assign target_addr = (req_op == OP_INSERT) ? next_code : req_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         op_q        <= OP_READ;
         wait_cnt    <= '0;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_data    <= '0;
         rsp_code    <= '0;
         ram_cs      <= 1'b0;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_data_in <= '0;
         next_code   <= FIRST_C;
         dict_full   <= 1'b0;
      end else begin
         // Clear takes priority over the allocation step of an in-flight insert.
         if (clear) begin
            next_code <= FIRST_C;
            dict_full <= 1'b0;
         end else if (state == ISSUE && op_q == OP_INSERT) begin
            if (next_code == LAST_C)
               dict_full <= 1'b1;
            else
               next_code <= next_code + 1'b1;
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  op_q     <= req_op;
                  rsp_code <= target_addr;
                  rsp_data <= '0;
                  if (accept_err) begin
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     rsp_err     <= 1'b0;
                     ram_cs      <= 1'b1;
                     ram_we      <= (req_op != OP_READ);
                     ram_addr    <= target_addr;
                     ram_data_in <= req_data;
                     state       <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (op_q == OP_READ) begin
                  wait_cnt <= '0;
                  state    <= WAIT;
               end else begin
                  ram_cs    <= 1'b0;
                  ram_we    <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            WAIT: begin
               if (ram_valid || wait_cnt == WAIT_LAST) begin
                  if (ram_valid)
                     rsp_data <= ram_data_out;
                  else
                     rsp_err <= 1'b1;
                  ram_cs    <= 1'b0;
                  ram_we    <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
